// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: state encoding,
// requester port indices and default line/address widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Grant state that serves the given port index.
    function automatic logic [1:0] grant_state(input logic idx);
        return (idx == PORT_D) ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection for two requesters.
// Ports: req_i[1:0], last_grant_i -> gnt_valid_o, gnt_idx_o.
// Build option MEM_ARB_RR_EN: round-robin on ties instead of PRIO_PORT.
module arb_grant_sel
    import mem_arb_pkg::*;
#(
    parameter int PRIO_PORT = 1
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic tie_idx;

`ifdef MEM_ARB_RR_EN
    logic prio_unused;

    // On a tie, serve the port that did not win last time.
    assign tie_idx     = ~last_grant_i;
    assign prio_unused = (PRIO_PORT != 0);
`else
    logic last_grant_unused;

    assign tie_idx           = (PRIO_PORT != 0) ? PORT_D : PORT_I;
    assign last_grant_unused = last_grant_i;
`endif

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = PORT_I;
        case (req_i)
            2'b01:   gnt_idx_o = PORT_I;
            2'b10:   gnt_idx_o = PORT_D;
            2'b11:   gnt_idx_o = tie_idx;
            default: gnt_idx_o = PORT_I;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache (port 0) and the
// D-cache (port 1). Grant is held until mem_ack_i; the response is steered
// back to the granted port only. Ports: p0_*/p1_* requester side,
// mem_* memory side, busy_o. Build option MEM_ARB_RR_EN (see arb_grant_sel).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PRIO_PORT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,

    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic              busy_o
);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] p0_data_q, p0_data_d;
    logic [DATA_W-1:0] p1_data_q, p1_data_d;

    logic gnt_valid;
    logic gnt_idx;

    arb_grant_sel #(
        .PRIO_PORT (PRIO_PORT)
    ) u_sel (
        .req_i        ({p1_enable_i, p0_enable_i}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_write_d  = mem_write_q;
        mem_data_d   = mem_data_q;
        p0_data_d    = p0_data_q;
        p1_data_d    = p1_data_q;
        p0_ack_o     = 1'b0;
        p1_ack_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // mem_ack_i is ignored here: it can only be a stretched
                // ack from a transaction that already completed.
                if (gnt_valid) begin
                    state_d = grant_state(gnt_idx);
                    if (gnt_idx == PORT_D) begin
                        mem_addr_d  = p1_addr_i;
                        mem_write_d = p1_write_i;
                        mem_data_d  = p1_data_i;
                    end else begin
                        mem_addr_d  = p0_addr_i;
                        mem_write_d = p0_write_i;
                        mem_data_d  = p0_data_i;
                    end
                end
            end
            ST_GRANT0: begin
                if (mem_ack_i) begin
                    p0_ack_o     = 1'b1;
                    state_d      = ST_IDLE;
                    last_grant_d = PORT_I;
                    mem_write_d  = 1'b0;
                    if (!mem_write_q) begin
                        p0_data_d = mem_data_i;
                    end
                end
            end
            ST_GRANT1: begin
                if (mem_ack_i) begin
                    p1_ack_o     = 1'b1;
                    state_d      = ST_IDLE;
                    last_grant_d = PORT_D;
                    mem_write_d  = 1'b0;
                    if (!mem_write_q) begin
                        p1_data_d = mem_data_i;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_I;
            mem_addr_q   <= '0;
            mem_write_q  <= 1'b0;
            mem_data_q   <= '0;
            p0_data_q    <= '0;
            p1_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_write_q  <= mem_write_d;
            mem_data_q   <= mem_data_d;
            p0_data_q    <= p0_data_d;
            p1_data_q    <= p1_data_d;
        end
    end

    // Read data is passed through in the ack cycle and held afterwards.
    assign p0_data_o = p0_ack_o ? mem_data_i : p0_data_q;
    assign p1_data_o = p1_ack_o ? mem_data_i : p1_data_q;

    assign busy_o       = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign mem_enable_o = busy_o;
    assign mem_addr_o   = mem_addr_q;
    assign mem_write_o  = mem_write_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed reset/read/write/reset-abort
// cases, a simultaneous-request ordering case and a random two-port phase.
module tb_mem_arbiter;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } exp_t;

    logic         clk;
    logic         rst_i;
    logic         p0_enable_i, p0_write_i;
    logic [31:0]  p0_addr_i;
    logic [255:0] p0_data_i, p0_data_o;
    logic         p0_ack_o;
    logic         p1_enable_i, p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [255:0] p1_data_i, p1_data_o;
    logic         p1_ack_o;
    logic [255:0] mem_data_i, mem_data_o;
    logic         mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o, mem_write_o, busy_o;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   ack_order[$];

    logic [255:0] store   [logic [31:0]];
    logic [255:0] ref_mem [logic [31:0]];

    bit mem_auto = 0;

    localparam logic [255:0] A5 = {32{8'hA5}};

    mem_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p0_enable_i  (p0_enable_i),
        .p0_write_i   (p0_write_i),
        .p0_addr_i    (p0_addr_i),
        .p0_data_i    (p0_data_i),
        .p0_data_o    (p0_data_o),
        .p0_ack_o     (p0_ack_o),
        .p1_enable_i  (p1_enable_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_ack_o     (p1_ack_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .busy_o       (busy_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [255:0] init_val(input logic [31:0] a);
        return {8{a ^ 32'hC3D2_E1F0}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic en, input logic wr,
                              input logic [31:0] a, input logic [255:0] d);
        if (p == 0) begin
            p0_enable_i = en; p0_write_i = wr;
            p0_addr_i = a;    p0_data_i = d;
        end else begin
            p1_enable_i = en; p1_write_i = wr;
            p1_addr_i = a;    p1_data_i = d;
        end
    endtask

    task automatic check_port(input int p);
        exp_t e;
        logic [255:0] d;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack port=%0d actual=1 required=0", p);
            return;
        end
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        d = (p == 0) ? p0_data_o : p1_data_o;
        chk($sformatf("ack_addr_p%0d", p), mem_addr_o, e.addr);
        chk($sformatf("ack_write_p%0d", p), mem_write_o, e.wr);
        if (!e.wr) chk($sformatf("rd_data_p%0d", p), d, e.data);
        ack_order.push_back(p);
    endtask

    // Monitor: pops the scoreboard whenever an ack is presented.
    initial forever begin
        @(negedge clk);
        if (p0_ack_o || p1_ack_o) begin
            chk("ack_exclusive", p0_ack_o & p1_ack_o, 1'b0);
            if (p0_ack_o) check_port(0);
            if (p1_ack_o) check_port(1);
        end
    end

    // Behavioural memory: random latency, occasionally stretched ack.
    initial begin : mem_model
        int cnt = -1;
        bit ext = 0;
        logic [31:0]  cap_a;
        logic         cap_w;
        logic [255:0] cap_d;
        forever begin
            @(posedge clk); #1;
            if (!mem_auto) begin
                cnt = -1; ext = 0;
                continue;
            end
            if (ext) begin
                ext = 0;
                continue;
            end
            mem_ack_i = 0;
            if (!mem_enable_o) begin
                cnt = -1;
                continue;
            end
            if (cnt < 0) begin
                cnt = $urandom_range(0, 5);
                cap_a = mem_addr_o; cap_w = mem_write_o; cap_d = mem_data_o;
            end else begin
                chk("mem_addr_stable", mem_addr_o, cap_a);
                chk("mem_write_stable", mem_write_o, cap_w);
                if (cap_w) chk("mem_data_stable", mem_data_o, cap_d);
            end
            if (cnt == 0) begin
                if (cap_w) store[cap_a] = cap_d;
                else mem_data_i = store.exists(cap_a) ? store[cap_a]
                                                      : init_val(cap_a);
                mem_ack_i = 1;
                ext = ($urandom_range(0, 3) == 0);
                cnt = -1;
            end else begin
                cnt--;
            end
        end
    end

    task automatic run_port(input int p, input int n, input int gapmax);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   gap;
            bit   got;
            e.wr   = 1'($urandom_range(0, 1));
            e.addr = (p == 1 ? 32'h0002_0000 : 32'h0001_0000)
                     + 32'($urandom_range(0, 7)) * 32;
            for (int k = 0; k < 8; k++) e.data[k*32 +: 32] = $urandom();
            if (e.wr) ref_mem[e.addr] = e.data;
            else e.data = ref_mem.exists(e.addr) ? ref_mem[e.addr]
                                                 : init_val(e.addr);
            if (p == 0) q0.push_back(e); else q1.push_back(e);
            drive_port(p, 1, e.wr, e.addr, e.data);
            got = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if ((p == 0) ? p0_ack_o : p1_ack_o) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL timeout_p%0d actual=no_ack required=ack", p);
            end
            @(posedge clk); #1;
            gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            if (gap > 0 || i == n - 1) begin
                drive_port(p, 0, 0, 0, 0);
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        rst_i = 1;
        mem_ack_i = 0;
        mem_data_i = '0;
        drive_port(0, 0, 0, 0, 0);
        drive_port(1, 1, 0, 32'h0000_0400, '0);

        // Reset with a pending p1 request.
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_enable", mem_enable_o, 1'b0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, '0);
        chk("rst_acks", {p0_ack_o, p1_ack_o}, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_p0_data", p0_data_o, '0);
        chk("rst_p1_data", p1_data_o, '0);
        @(posedge clk); #1;
        rst_i = 0;
        @(negedge clk);
        chk("idle_after_rst", busy_o, 1'b0);
        @(negedge clk);
        chk("grant_after_rst", mem_enable_o, 1'b1);
        chk("rd_addr", mem_addr_o, 32'h400);
        chk("rd_write", mem_write_o, 1'b0);
        q1.push_back('{wr: 1'b0, addr: 32'h400, data: A5});

        // Single read, memory acks after 10 cycles.
        repeat (10) @(posedge clk);
        #1;
        mem_ack_i = 1;
        mem_data_i = A5;
        @(negedge clk);
        chk("rd_p1_ack", p1_ack_o, 1'b1);
        chk("rd_p0_ack", p0_ack_o, 1'b0);
        @(posedge clk); #1;
        mem_ack_i = 0;
        mem_data_i = '0;
        drive_port(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rd_ack_pulse", p1_ack_o, 1'b0);
        chk("rd_data_hold", p1_data_o, A5);
        chk("rd_done_idle", busy_o, 1'b0);

        // Single write on port 0.
        @(posedge clk); #1;
        drive_port(0, 1, 1, 32'h20, 256'h1234);
        q0.push_back('{wr: 1'b1, addr: 32'h20, data: 256'h1234});
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wr_enable", mem_enable_o, 1'b1);
            chk("wr_write", mem_write_o, 1'b1);
            chk("wr_addr", mem_addr_o, 32'h20);
            chk("wr_data", mem_data_o, 256'h1234);
        end
        @(posedge clk); #1;
        mem_ack_i = 1;
        @(negedge clk);
        chk("wr_p0_ack", p0_ack_o, 1'b1);
        chk("wr_p1_ack", p1_ack_o, 1'b0);
        @(posedge clk); #1;
        mem_ack_i = 0;
        drive_port(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wr_ack_pulse", p0_ack_o, 1'b0);

        // Reset three cycles into a p0 read, then a stray ack in IDLE.
        @(posedge clk); #1;
        drive_port(0, 1, 0, 32'h40, '0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_granted", busy_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1;
        drive_port(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_i = 0;
        mem_ack_i = 1;
        mem_data_i = '1;
        @(negedge clk);
        chk("abort_acks", {p0_ack_o, p1_ack_o}, 2'b00);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_p1_data", p1_data_o, '0);
        @(posedge clk); #1;
        mem_ack_i = 0;
        @(negedge clk);
        chk("abort_idle", busy_o, 1'b0);
        chk("abort_enable", mem_enable_o, 1'b0);

        // Simultaneous continuous requests from a fresh reset.
        mem_auto = 1;
        @(posedge clk); #1;
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        ack_order.delete();
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 0, 0};
`endif
        fork
            run_port(0, 2, 0);
            run_port(1, 2, 0);
        join
        chk("order_len", ack_order.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("order_%0d", i),
                (i < ack_order.size()) ? ack_order[i] : 99, exp_order[i]);
        end

        // Random traffic on both ports.
        fork
            run_port(0, 25, 3);
            run_port(1, 25, 3);
        join
        repeat (4) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single off-chip Data Memory port (256-bit line, enable/write/ack handshake) between two cache requesters: port 0 (instruction cache) and port 1 (data cache).
- Sits between the CPU's caches and Data_Memory; replaces the direct dcache-to-memory wiring at the CPU top level.
- Grants one requester at a time and holds the grant until the memory acks.
- Steers the memory response back to the granted requester only.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 256, cache-line width in bits
PRIO_PORT, 1, port that wins simultaneous requests in fixed-priority mode (0 or 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
p0_enable_i  in  1  port 0 request; held high until p0_ack_o
p0_write_i  in  1  port 0: 1 = line write, 0 = line read
p0_addr_i  in  ADDR_W  port 0 line address
p0_data_i  in  DATA_W  port 0 write data
p0_data_o  out  DATA_W  port 0 read data; valid when p0_ack_o=1
p0_ack_o  out  1  port 0 transaction complete
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o  (same as port 0, for port 1)
mem_data_i  in  DATA_W  memory read data
mem_ack_i  in  1  memory done pulse
mem_data_o  out  DATA_W  memory write data
mem_addr_o  out  ADDR_W  memory address
mem_enable_o  out  1  memory request
mem_write_o  out  1  memory write strobe
busy_o  out  1  high while in GRANT0 or GRANT1

Behaviour:
- States are IDLE, GRANT0 and GRANT1, held in a registered state plus a last_grant bit.
- Reset (synchronous, on the rising clk_i edge with rst_i=1):
  - state=IDLE, last_grant=0.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - p0_ack_o=p1_ack_o=0, p0_data_o=p1_data_o=0, busy_o=0.
  - Reset mid-transaction abandons it. Memory shares rst_i, so no stale ack is expected; any mem_ack_i seen while in IDLE is ignored.
- IDLE: on each cycle, sample p0_enable_i and p1_enable_i.
  - Only one asserted: go to that port's GRANT state.
  - Both asserted: the winner comes from the selector (fixed PRIO_PORT, or round-robin under the option).
  - Neither asserted: stay in IDLE.
  - Arbitration decision to mem_enable_o=1 takes 1 cycle.
- GRANTn:
  - mem_enable_o=1.
  - mem_addr_o, mem_write_o and mem_data_o are registered copies of port n's inputs, captured on the transition into GRANTn and held constant for the whole transaction.
  - The other port's ack stays 0. Its request waits, with no loss.
- Completion: when mem_ack_i=1 in GRANTn:
  - pn_ack_o=1 for that same cycle (combinational).
  - pn_data_o=mem_data_i for a read; pn_data_o is don't-care for a write.
  - Next state is IDLE, last_grant=n, and mem_enable_o drops the following cycle.
  - Minimum turnaround is 1 IDLE cycle between back-to-back transactions.
- Requester deasserts enable before its ack: the transaction still completes and the ack is still delivered. The requester must ignore it.
- The ack pulse is exactly 1 cycle per transaction. pn_data_o holds its last value when the ack is low.
- mem_ack_i staying high for more than 1 cycle: only the first cycle counts; the arbiter is already in IDLE on the next cycle.
- Starvation: in fixed mode the non-priority port can starve. This is accepted because the caches stall the pipeline and never request continuously.

Optional Feature:
MEM_ARB_RR_EN
- Defined: simultaneous requests in IDLE are granted to the port opposite last_grant (round-robin); PRIO_PORT is ignored.
- Undefined: simultaneous requests always go to PRIO_PORT; last_grant is still tracked but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2);
  - port index constants (PORT_I=0, PORT_D=1);
  - default widths.
- Sub-module arb_grant_sel (combinational) holds the winner selection: inputs req[1:0], last_grant, PRIO_PORT; outputs gnt_valid and gnt_idx. The macro affects this sub-module only.

Test Plan:
- Reset check: rst_i=1 for 2 cycles with p1_enable_i=1 -> mem_enable_o=0, both acks 0, busy_o=0; the request is granted 1 cycle after rst_i falls.
- Single read: p1 read at addr 0x0000_0400, memory acks after 10 cycles with data 256'hA5..A5 -> mem_addr_o=0x400, mem_write_o=0; p1_ack_o pulses 1 cycle with p1_data_o=A5..A5; p0_ack_o stays 0.
- Single write: p0 write at addr 0x20 with data 256'h1234 -> mem_write_o=1, mem_data_o=0x1234 held until ack; p0_ack_o pulses once.
- Simultaneous requests, fixed mode (PRIO_PORT=1): p0 and p1 assert in the same cycle -> p1 is served first; p0 is granted 1 IDLE cycle after p1_ack_o, and mem_addr_o switches only at that point.
- Simultaneous requests with MEM_ARB_RR_EN and both held continuously for 4 transactions -> grants alternate 1,0,1,0 (last_grant reset 0 ⇒ first grant to port 1).
- Reset mid-op: assert rst_i 3 cycles into a p0 transaction, then the memory returns mem_ack_i=1 in IDLE -> no ack on either port, state stays IDLE.
